csc_pipe: RTL and testbench
===========================

CSC_PIPE -- requirements
Module: csc_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per colour component.
REQ-002 SHALL have parameter COEF_WIDTH, default 10, meaning signed coefficient width, with 8 fractional bits.
REQ-003 SHALL have port clk  in  1  the only clock; all logic is rising-edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have ports i_vsync, i_hsync, i_de  in  1 each  video sync and data-enable inputs.
REQ-006 SHALL have port i_data  in  3*DATA_WIDTH  pixel as {c2,c1,c0}, c0 in the LSBs.
REQ-007 SHALL have ports i_csc_coef00..i_csc_coef22  in  COEF_WIDTH each  coefficient matrix from the register block (9 ports).
REQ-008 SHALL have ports i_csc_bias0..i_csc_bias2  in  8 each  unsigned output biases.
REQ-009 SHALL have port i_csc_bypass  in  1  bypass request.
REQ-010 SHALL have ports o_vsync, o_hsync, o_de  out  1 each  delayed sync outputs.
REQ-011 SHALL have port o_data  out  3*DATA_WIDTH  converted pixel as {o2,o1,o0}.

Function
REQ-012 SHALL hold shadow copies of all 9 coefficients, 3 biases and bypass.
REQ-013 SHALL load the shadow copies only in the cycle where i_vsync is 1 and the registered previous i_vsync is 0 (rising edge).
REQ-014 SHALL let the loaded shadow values take effect from the pixel presented in the cycle after that edge.
REQ-015 SHALL NOT let register-block changes between vsync rising edges affect output.
REQ-016 SHALL compute each output channel k as o_k = clip(((coef_k0*c0 + coef_k1*c1 + coef_k2*c2 + 128) >>> 8) + bias_k, 0, 255).
REQ-017 SHALL apply these arithmetic rules: data zero-extended (unsigned); coefficients two's complement; products at least 19 bits signed; sum at least 21 bits signed.
REQ-018 SHALL make >>> an arithmetic shift, i.e. floor toward minus infinity.
REQ-019 SHALL compute the bias add in signed arithmetic before the clip.
REQ-020 SHALL use a fixed three-stage pipeline.
- S1: register the 9 products.
- S2: register the 3 rounded sums.
- S3: shift, add bias, clip, register outputs.
REQ-021 SHALL have a latency of exactly 3 clk from i_data/i_de/i_hsync/i_vsync to o_data/o_de/o_hsync/o_vsync.
REQ-022 SHALL delay the sync signals through a matching 3-deep shift register.
REQ-023 SHALL accept a new pixel every cycle, with no backpressure.
REQ-024 SHALL compute on every cycle regardless of i_de; o_data is don't-care when o_de is 0 but SHALL be deterministic.
REQ-025 SHALL, when shadow bypass is 1, pass i_data unchanged to o_data with the same 3-cycle latency.
REQ-026 SHALL keep bypass switching only at vsync rising edges, with no latency change and no dropped or duplicated pixels.
REQ-027 SHALL, if i_vsync is held high for multiple cycles, load the shadows once, at the first cycle only.
REQ-028 SHALL, if a vsync edge and a register-block change occur in the same cycle, capture the value present on the inputs in that cycle.

Reset
REQ-029 SHALL, while rst is 1 at a clk edge, clear all pipeline registers, o_data, o_de, o_hsync and o_vsync to 0.
REQ-030 SHALL, while rst is 1, clear all shadow coefficients, biases and bypass to 0, and clear the vsync edge register to 0.
REQ-031 SHALL treat an i_vsync of 1 in the first cycle after rst deasserts as a rising edge.
REQ-032 SHALL, on reset mid-frame, discard in-flight pixels and drive outputs to 0 on the next edge.

Verification
REQ-033 SHALL cover the identity matrix: coef00=coef11=coef22=10'h100, others 0, biases 0, vsync pulse, then pixel {200,150,100} with de=1 -> exactly 3 cycles later o_data={200,150,100}, o_de=1.
REQ-034 SHALL cover the positive clip: coef00=10'h1FF, c0=255 -> o0=255.
REQ-035 SHALL cover the negative clip: coef00=10'h300 (-1.0), c0=10, bias0=0 -> o0=0; the same with bias0=20 -> o0=10.
REQ-036 SHALL cover shadowing: change coef00 from 10'h100 to 10'h080 mid-frame -> o0 stays unchanged until the pixel after the next vsync rising edge, then halves (c0=100 -> 50).
REQ-037 SHALL cover bypass: set bypass=1 plus a vsync edge, then stream a ramp 0..255 with arbitrary coefficients -> o_data equals the input ramp delayed 3 cycles, with no gaps.
REQ-038 SHALL cover reset mid-stream: assert rst for 1 cycle during a de=1 burst -> next cycle all outputs 0, shadows 0; after a fresh vsync, the identity test passes again.

Source files
------------

// File: rtl/csc_pipe.sv
// Three-stage colour-space converter: 3x3 signed matrix, rounding, bias, clip.
// Coefficients, biases and bypass are shadowed and reloaded on each vsync rising edge.
module csc_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_vsync,
  input  logic                    i_hsync,
  input  logic                    i_de,
  input  logic [3*DATA_WIDTH-1:0] i_data,
  input  logic [COEF_WIDTH-1:0]   i_csc_coef00,
  input  logic [COEF_WIDTH-1:0]   i_csc_coef01,
  input  logic [COEF_WIDTH-1:0]   i_csc_coef02,
  input  logic [COEF_WIDTH-1:0]   i_csc_coef10,
  input  logic [COEF_WIDTH-1:0]   i_csc_coef11,
  input  logic [COEF_WIDTH-1:0]   i_csc_coef12,
  input  logic [COEF_WIDTH-1:0]   i_csc_coef20,
  input  logic [COEF_WIDTH-1:0]   i_csc_coef21,
  input  logic [COEF_WIDTH-1:0]   i_csc_coef22,
  input  logic [7:0]              i_csc_bias0,
  input  logic [7:0]              i_csc_bias1,
  input  logic [7:0]              i_csc_bias2,
  input  logic                    i_csc_bypass,
  output logic                    o_vsync,
  output logic                    o_hsync,
  output logic                    o_de,
  output logic [3*DATA_WIDTH-1:0] o_data
);

  localparam int FRAC_BITS = 8;
  localparam int PROD_W    = COEF_WIDTH + DATA_WIDTH + 1;
  localparam int SUM_W     = PROD_W + 2;
  localparam int RES_W     = SUM_W + 1;
  localparam int ROUND     = 1 << (FRAC_BITS - 1);

  // Matrix index is row*3 + column, i.e. coef_in[k*3+j] multiplies c_j into o_k.
  logic [COEF_WIDTH-1:0] coef_in [9];
  logic [7:0]            bias_in [3];

  assign coef_in[0] = i_csc_coef00;
  assign coef_in[1] = i_csc_coef01;
  assign coef_in[2] = i_csc_coef02;
  assign coef_in[3] = i_csc_coef10;
  assign coef_in[4] = i_csc_coef11;
  assign coef_in[5] = i_csc_coef12;
  assign coef_in[6] = i_csc_coef20;
  assign coef_in[7] = i_csc_coef21;
  assign coef_in[8] = i_csc_coef22;
  assign bias_in[0] = i_csc_bias0;
  assign bias_in[1] = i_csc_bias1;
  assign bias_in[2] = i_csc_bias2;

  logic                  vsync_prev_reg;
  logic                  vs_rise;
  logic [COEF_WIDTH-1:0] coef_sh_reg [9];
  logic [7:0]            bias_sh_reg [3];
  logic                  bypass_sh_reg;

  assign vs_rise = i_vsync & ~vsync_prev_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      vsync_prev_reg <= 1'b0;
      bypass_sh_reg  <= 1'b0;
      for (int i = 0; i < 9; i++) coef_sh_reg[i] <= '0;
      for (int i = 0; i < 3; i++) bias_sh_reg[i] <= '0;
    end else begin
      vsync_prev_reg <= i_vsync;
      if (vs_rise) begin
        bypass_sh_reg <= i_csc_bypass;
        for (int i = 0; i < 9; i++) coef_sh_reg[i] <= coef_in[i];
        for (int i = 0; i < 3; i++) bias_sh_reg[i] <= bias_in[i];
      end
    end
  end

  logic signed [PROD_W-1:0]     prod_reg [9];
  logic signed [PROD_W-1:0]     prod_next [9];
  logic signed [SUM_W-1:0]      sum_reg [3];
  logic signed [SUM_W-1:0]      sum_next [3];
  logic [DATA_WIDTH-1:0]        out_reg [3];
  logic [DATA_WIDTH-1:0]        out_next [3];
  // Bias and bypass travel with the pixel so a shadow reload never splits one pixel.
  logic [7:0]                   bias_d1_reg [3];
  logic [7:0]                   bias_d2_reg [3];
  logic                         byp_d1_reg;
  logic                         byp_d2_reg;
  logic [3*DATA_WIDTH-1:0]      data_d1_reg;
  logic [3*DATA_WIDTH-1:0]      data_d2_reg;
  logic [2:0]                   sync_d1_reg;
  logic [2:0]                   sync_d2_reg;
  logic [2:0]                   sync_d3_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_prod
      logic signed [PROD_W-1:0] coef_ext;
      logic signed [PROD_W-1:0] pix_ext;
      assign coef_ext      = PROD_W'($signed(coef_sh_reg[gi]));
      assign pix_ext       = PROD_W'(i_data[(gi % 3)*DATA_WIDTH +: DATA_WIDTH]);
      assign prod_next[gi] = coef_ext * pix_ext;
    end

    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic signed [SUM_W-1:0] shifted;
      logic signed [RES_W-1:0] res;
      assign sum_next[gi] = SUM_W'(prod_reg[3*gi]) + SUM_W'(prod_reg[3*gi+1])
                          + SUM_W'(prod_reg[3*gi+2]) + SUM_W'(ROUND);
      assign shifted      = sum_reg[gi] >>> FRAC_BITS;
      assign res          = RES_W'(shifted) + RES_W'(bias_d2_reg[gi]);
      // Sign bit set means below zero; any bit above the component width means overflow.
      assign out_next[gi] = byp_d2_reg                   ? data_d2_reg[gi*DATA_WIDTH +: DATA_WIDTH] :
                            res[RES_W-1]                 ? '0 :
                            (|res[RES_W-2:DATA_WIDTH])   ? '1 :
                                                           res[DATA_WIDTH-1:0];
      assign o_data[gi*DATA_WIDTH +: DATA_WIDTH] = out_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) prod_reg[i] <= '0;
      for (int i = 0; i < 3; i++) begin
        sum_reg[i]     <= '0;
        out_reg[i]     <= '0;
        bias_d1_reg[i] <= '0;
        bias_d2_reg[i] <= '0;
      end
      byp_d1_reg  <= 1'b0;
      byp_d2_reg  <= 1'b0;
      data_d1_reg <= '0;
      data_d2_reg <= '0;
      sync_d1_reg <= '0;
      sync_d2_reg <= '0;
      sync_d3_reg <= '0;
    end else begin
      for (int i = 0; i < 9; i++) prod_reg[i] <= prod_next[i];
      for (int i = 0; i < 3; i++) begin
        sum_reg[i]     <= sum_next[i];
        out_reg[i]     <= out_next[i];
        bias_d1_reg[i] <= bias_sh_reg[i];
        bias_d2_reg[i] <= bias_d1_reg[i];
      end
      byp_d1_reg  <= bypass_sh_reg;
      byp_d2_reg  <= byp_d1_reg;
      data_d1_reg <= i_data;
      data_d2_reg <= data_d1_reg;
      sync_d1_reg <= {i_vsync, i_hsync, i_de};
      sync_d2_reg <= sync_d1_reg;
      sync_d3_reg <= sync_d2_reg;
    end
  end

  assign {o_vsync, o_hsync, o_de} = sync_d3_reg;

endmodule

// File: tb/tb_csc_pipe.sv
// Directed bench for csc_pipe: each step queues a hand-computed expectation that
// is checked when that pixel emerges three clocks later.
module tb_csc_pipe;

  logic        clk;
  logic        rst;
  logic        i_vsync, i_hsync, i_de;
  logic [23:0] i_data;
  logic [9:0]  coef [9];
  logic [7:0]  bias [3];
  logic        i_csc_bypass;
  logic        o_vsync, o_hsync, o_de;
  logic [23:0] o_data;

  int n_assert = 0;
  int n_fail   = 0;
  int step_no  = 0;

  typedef struct {
    logic        chk;
    logic [23:0] data;
    logic [2:0]  sync;
  } exp_t;
  exp_t exp_q[$];

  csc_pipe #(.DATA_WIDTH(8), .COEF_WIDTH(10)) dut (
    .clk(clk), .rst(rst),
    .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de), .i_data(i_data),
    .i_csc_coef00(coef[0]), .i_csc_coef01(coef[1]), .i_csc_coef02(coef[2]),
    .i_csc_coef10(coef[3]), .i_csc_coef11(coef[4]), .i_csc_coef12(coef[5]),
    .i_csc_coef20(coef[6]), .i_csc_coef21(coef[7]), .i_csc_coef22(coef[8]),
    .i_csc_bias0(bias[0]), .i_csc_bias1(bias[1]), .i_csc_bias2(bias[2]),
    .i_csc_bypass(i_csc_bypass),
    .o_vsync(o_vsync), .o_hsync(o_hsync), .o_de(o_de), .o_data(o_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of input; afterwards outputs correspond to the step two calls earlier.
  task automatic step(input logic vs, input logic hs, input logic de,
                      input logic [23:0] d, input logic chk, input logic [23:0] e);
    exp_t x;
    exp_t y;
    i_vsync = vs; i_hsync = hs; i_de = de; i_data = d;
    x.chk = chk; x.data = e; x.sync = {vs, hs, de};
    exp_q.push_back(x);
    step_no++;
    @(negedge clk);
    if (exp_q.size() == 3) begin
      y = exp_q.pop_front();
      check($sformatf("sync@step%0d", step_no - 2), {21'b0, o_vsync, o_hsync, o_de}, {21'b0, y.sync});
      if (y.chk) check($sformatf("data@step%0d", step_no - 2), o_data, y.data);
    end
  endtask

  task automatic px(input logic [23:0] d, input logic [23:0] e);
    step(1'b0, 1'b0, 1'b1, d, 1'b1, e);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
  endtask

  task automatic set_coefs(input logic [9:0] a0, input logic [9:0] a1, input logic [9:0] a2,
                           input logic [9:0] a3, input logic [9:0] a4, input logic [9:0] a5,
                           input logic [9:0] a6, input logic [9:0] a7, input logic [9:0] a8);
    coef[0] = a0; coef[1] = a1; coef[2] = a2;
    coef[3] = a3; coef[4] = a4; coef[5] = a5;
    coef[6] = a6; coef[7] = a7; coef[8] = a8;
  endtask

  task automatic set_bias(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    bias[0] = b0; bias[1] = b1; bias[2] = b2;
  endtask

  // One reset edge while a de=1 burst is on the inputs; everything must read 0 right after.
  task automatic do_reset(input logic vs);
    exp_t z;
    rst = 1'b1; i_vsync = vs; i_hsync = 1'b0; i_de = 1'b1; i_data = 24'hFFFFFF;
    @(negedge clk);
    check("reset_data", o_data, 24'h0);
    check("reset_sync", {21'b0, o_vsync, o_hsync, o_de}, 24'h0);
    rst = 1'b0;
    exp_q.delete();
    z.chk = 1'b1; z.data = 24'h0; z.sync = 3'b000;
    exp_q.push_back(z);
    exp_q.push_back(z);
  endtask

  initial begin
    logic [7:0]  b;
    logic [23:0] d;
    rst = 1'b1; i_vsync = 1'b0; i_hsync = 1'b0; i_de = 1'b0; i_data = 24'h0;
    i_csc_bypass = 1'b0;
    set_coefs(10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0, 10'h0);
    set_bias(8'd0, 8'd0, 8'd0);
    do_reset(1'b0);

    // Identity; the pixel in the edge cycle still sees the cleared shadow.
    set_coefs(10'h100, 10'h0, 10'h0, 10'h0, 10'h100, 10'h0, 10'h0, 10'h0, 10'h100);
    step(1'b1, 1'b0, 1'b0, 24'h010203, 1'b1, 24'h000000);
    px(24'hC89664, 24'hC89664);

    // Positive clip: 511*255 -> 509 -> 255.
    coef[0] = 10'h1FF;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
    px(24'h004DFF, 24'h004DFF);

    // Negative clip and floor rounding with coef00 = -1.0.
    coef[0] = 10'h300;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
    px(24'h00000A, 24'h000000);
    bias[0] = 8'd20;
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
    px(24'h00000A, 24'h00000A);
    px(24'h000001, 24'h000013);

    // Mixed signs across all rows: {40,100,200} -> {28,218,200}.
    set_coefs(10'h100, 10'h000, 10'h000, 10'h040, 10'h080, 10'h3C0, 10'h3E0, 10'h3A0, 10'h100);
    set_bias(8'd0, 8'd128, 8'd50);
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
    px(24'h2864C8, 24'h1CDAC8);

    // Shadowing, same-cycle capture and a vsync held high for two cycles.
    set_coefs(10'h100, 10'h0, 10'h0, 10'h0, 10'h100, 10'h0, 10'h0, 10'h0, 10'h100);
    set_bias(8'd0, 8'd0, 8'd0);
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
    px(24'h000064, 24'h000064);
    coef[0] = 10'h080;
    px(24'h000064, 24'h000064);
    step(1'b1, 1'b0, 1'b0, 24'h000064, 1'b1, 24'h000064);
    coef[0] = 10'h040;
    step(1'b1, 1'b0, 1'b1, 24'h000064, 1'b1, 24'h000032);
    px(24'h000064, 24'h000032);
    px(24'h000064, 24'h000032);

    // Bypass ramp with arbitrary coefficients; request drops mid-frame without effect.
    i_csc_bypass = 1'b1;
    set_coefs(10'h2AB, 10'h1C3, 10'h355, 10'h0F0, 10'h3FF, 10'h123, 10'h200, 10'h1FF, 10'h07A);
    set_bias(8'd77, 8'd200, 8'd13);
    step(1'b1, 1'b0, 1'b0, 24'h0, 1'b0, 24'h0);
    for (int i = 0; i < 256; i++) begin
      b = i[7:0];
      d = {b, ~b, b ^ 8'h5A};
      if (i == 128) begin
        i_csc_bypass = 1'b0;
        coef[0] = 10'h1FF;
      end
      step(1'b0, (b[3:0] == 4'h0), 1'b1, d, 1'b1, d);
    end

    // Leave bypass at an edge: edge pixel still bypassed, the next gets +5 bias.
    set_coefs(10'h100, 10'h0, 10'h0, 10'h0, 10'h100, 10'h0, 10'h0, 10'h0, 10'h100);
    set_bias(8'd5, 8'd5, 8'd5);
    step(1'b1, 1'b0, 1'b1, 24'h646464, 1'b1, 24'h646464);
    px(24'h646464, 24'h696969);

    // Reset during a burst clears pipeline and shadows.
    px(24'h0A0B0C, 24'h0F1011);
    px(24'h0A0B0C, 24'h0F1011);
    px(24'h0A0B0C, 24'h0F1011);
    do_reset(1'b0);
    px(24'hC89664, 24'h000000);
    idle();
    idle();

    // vsync high straight out of reset counts as an edge; identity works again.
    set_bias(8'd0, 8'd0, 8'd0);
    do_reset(1'b1);
    step(1'b1, 1'b0, 1'b1, 24'hC89664, 1'b1, 24'h000000);
    px(24'hC89664, 24'hC89664);
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
